// File: rtl/scan_sel_ctrl.sv
// Scan sequencer for a downstream 3-to-8 decoder: steps through the enabled
// mask positions, holding E high for a dwell time and low for an optional gap.
module scan_sel_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] mask,
    input  logic [7:0] dwell,
    input  logic [3:0] blank,
    output logic       E,
    output logic [2:0] In,
    output logic       busy,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t     state_q;
    logic [2:0] in_q;
    logic       e_q;
    logic       busy_q;
    logic       wrap_q;
    logic [7:0] cnt_q;
    logic [7:0] dwell_q;
    logic [3:0] blank_q;

    logic       mask_nz;
    logic [2:0] first_idx_d;
    logic [2:0] rot_idx [8];
    logic [7:0] rot_mask;
    logic [2:0] step_d;
    logic [2:0] next_idx_d;
    logic       wrap_d;
    logic       end_dwell;
    logic       end_blank;

    assign mask_nz = |mask;

    // Mask rotated so bit k is the position k+1 steps above the current index.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_idx[gi]  = in_q + 3'(gi + 1);
            assign rot_mask[gi] = mask[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        first_idx_d = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (mask[k]) first_idx_d = 3'(k);
        end
    end

    always_comb begin
        step_d = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (rot_mask[k]) step_d = 3'(k);
        end
    end

    // A lone set bit at the current index rotates to step 7, landing on itself.
    assign next_idx_d = in_q + step_d + 3'd1;
    assign wrap_d     = (next_idx_d <= in_q);

    assign end_dwell = (state_q == DWELL) && (cnt_q == dwell_q);
    assign end_blank = (state_q == BLANK) && (cnt_q == {4'd0, blank_q - 4'd1});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            in_q    <= 3'd0;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= 8'd0;
            dwell_q <= 8'd0;
            blank_q <= 4'd0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop && mask_nz) begin
                        state_q <= DWELL;
                        in_q    <= first_idx_d;
                        e_q     <= 1'b1;
                        busy_q  <= 1'b1;
                        dwell_q <= dwell;
                        cnt_q   <= 8'd0;
                    end
                end
                DWELL, BLANK: begin
                    if (stop) begin
                        state_q <= IDLE;
                        e_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt_q   <= 8'd0;
                    end else if (end_dwell && (blank != 4'd0)) begin
                        state_q <= BLANK;
                        e_q     <= 1'b0;
                        blank_q <= blank;
                        cnt_q   <= 8'd0;
                    end else if (end_dwell || end_blank) begin
                        cnt_q <= 8'd0;
                        if (mask_nz) begin
                            state_q <= DWELL;
                            in_q    <= next_idx_d;
                            wrap_q  <= wrap_d;
                            e_q     <= 1'b1;
                            dwell_q <= dwell;
                        end else begin
                            state_q <= IDLE;
                            e_q     <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    e_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    assign E    = e_q;
    assign In   = in_q;
    assign busy = busy_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_sel_ctrl.sv
// Directed bench for scan_sel_ctrl: hand-computed E/In/busy/wrap sequences.
module tb_scan_sel_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic [3:0] blank;
    logic       E;
    logic [2:0] In;
    logic       busy;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    scan_sel_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .mask  (mask),
        .dwell (dwell),
        .blank (blank),
        .E     (E),
        .In    (In),
        .busy  (busy),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic e_x, input logic [2:0] in_x,
                             input logic busy_x, input logic wrap_x);
        check_val({tag, ".E"}, 32'(E), 32'(e_x));
        check_val({tag, ".In"}, 32'(In), 32'(in_x));
        check_val({tag, ".busy"}, 32'(busy), 32'(busy_x));
        check_val({tag, ".wrap"}, 32'(wrap), 32'(wrap_x));
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    logic [2:0] seq_in [13];
    logic       seq_e  [13];
    logic       seq_w  [13];
    logic       w35    [6];
    int         wrap_seen;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        mask = 8'h00; dwell = 8'd0; blank = 4'd0;
        step(); step();
        check_out("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_out("idle_after_rst", 1'b0, 3'd0, 1'b0, 1'b0);

        // Full mask, no dwell, no gap: one position per cycle.
        mask = 8'hFF; dwell = 8'd0; blank = 4'd0; start = 1'b1;
        step(); start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check_out($sformatf("ff_c%0d", i), 1'b1, 3'(i % 8), 1'b1, (i == 8));
            if (i < 8) step();
        end
        pulse_stop();
        check_out("ff_stop", 1'b0, 3'd0, 1'b0, 1'b0);

        // Sparse mask with dwell=2 and a one-cycle gap.
        seq_in = '{3'd2,3'd2,3'd2,3'd2,3'd5,3'd5,3'd5,3'd5,3'd7,3'd7,3'd7,3'd7,3'd2};
        seq_e  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1};
        seq_w  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
        mask = 8'b1010_0100; dwell = 8'd2; blank = 4'd1; start = 1'b1;
        step(); start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            check_out($sformatf("a4_c%0d", i), seq_e[i], seq_in[i], 1'b1, seq_w[i]);
            if (i < 12) step();
        end
        pulse_stop();
        check_out("a4_stop", 1'b0, 3'd2, 1'b0, 1'b0);

        // Single bit: index holds, wrap every dwell+1 cycles.
        w35 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        mask = 8'h10; dwell = 8'd1; blank = 4'd0; start = 1'b1;
        step(); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_out($sformatf("single_c%0d", i), 1'b1, 3'd4, 1'b1, w35[i]);
            if (i < 5) step();
        end
        pulse_stop();
        check_out("single_stop", 1'b0, 3'd4, 1'b0, 1'b0);

        // Start with empty mask, then start+stop together: both ignored.
        mask = 8'h00; start = 1'b1;
        step(); start = 1'b0;
        check_out("empty_start", 1'b0, 3'd4, 1'b0, 1'b0);
        step();
        check_out("empty_start2", 1'b0, 3'd4, 1'b0, 1'b0);
        mask = 8'hFF; start = 1'b1; stop = 1'b1;
        step(); start = 1'b0; stop = 1'b0;
        check_out("start_and_stop", 1'b0, 3'd4, 1'b0, 1'b0);

        // Stop during the gap at In=3.
        mask = 8'h08; dwell = 8'd0; blank = 4'd3; start = 1'b1;
        step(); start = 1'b0;
        check_out("blk_dwell", 1'b1, 3'd3, 1'b1, 1'b0);
        step();
        check_out("blk_gap", 1'b0, 3'd3, 1'b1, 1'b0);
        pulse_stop();
        check_out("blk_stop", 1'b0, 3'd3, 1'b0, 1'b0);

        // Reset mid-dwell at In=6, with start also high: reset wins.
        mask = 8'h40; dwell = 8'd5; blank = 4'd0; start = 1'b1;
        step(); start = 1'b0;
        step();
        check_out("rst_pre", 1'b1, 3'd6, 1'b1, 1'b0);
        rst = 1'b1; start = 1'b1;
        step(); rst = 1'b0; start = 1'b0;
        check_out("rst_mid", 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        check_out("rst_wait", 1'b0, 3'd0, 1'b0, 1'b0);

        // Mask cleared mid-dwell (dwell change ignored too): idle at end, no wrap.
        mask = 8'h02; dwell = 8'd2; blank = 4'd0; start = 1'b1;
        step(); start = 1'b0;
        check_out("clr_c0", 1'b1, 3'd1, 1'b1, 1'b0);
        mask = 8'h00; dwell = 8'd0;
        step();
        check_out("clr_c1", 1'b1, 3'd1, 1'b1, 1'b0);
        step();
        check_out("clr_c2", 1'b1, 3'd1, 1'b1, 1'b0);
        step();
        check_out("clr_end", 1'b0, 3'd1, 1'b0, 1'b0);

        // Maximum dwell: 256 cycles before the first wrap.
        mask = 8'h01; dwell = 8'd255; blank = 4'd0; start = 1'b1;
        step(); start = 1'b0;
        wrap_seen = 0;
        for (int i = 0; i < 255; i++) begin
            if (wrap || !E) wrap_seen++;
            step();
        end
        if (wrap || !E) wrap_seen++;
        check_val("dw255_hold", 32'(wrap_seen), 32'd0);
        step();
        check_out("dw255_wrap", 1'b1, 3'd0, 1'b1, 1'b1);
        pulse_stop();
        check_out("dw255_stop", 1'b0, 3'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_sel_ctrl.md
SCAN_SEL_CTRL -- requirements
Module: scan_sel_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all ports are listed below with the clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  single-cycle request to begin scanning.
REQ-005 stop  input  1  single-cycle request to end scanning.
REQ-006 mask  input  8  bit i=1 enables decoder output i for the scan.
REQ-007 dwell  input  8  enable-high time per position; actual time = dwell+1 cycles.
REQ-008 blank  input  4  E-low gap between positions, in cycles (0 = no gap).
REQ-009 E  output  1  enable to the downstream 3-to-8 decoder.
REQ-010 In  output  3  select index to the downstream 3-to-8 decoder.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 wrap  output  1  one-cycle pulse when the index wraps to a position at or below the current one.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, DWELL, BLANK.
REQ-014 E SHALL be 1 only in DWELL; In SHALL be stable for the whole DWELL and the following BLANK.
REQ-015 All outputs SHALL be registered, with no combinational path from any input to E, In, busy or wrap.
REQ-016 IDLE: when start=1, stop=0 and mask!=0, the FSM SHALL go to DWELL on the next edge, with In = lowest set bit of mask and E=1 on that cycle.
REQ-017 IDLE: a start with mask==0 SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-018 DWELL: dwell SHALL be sampled on DWELL entry, and E SHALL stay high for exactly dwell+1 cycles; dwell=255 gives 256 cycles.
REQ-019 DWELL end with sampled blank!=0: the FSM SHALL go to BLANK for exactly blank cycles, with E=0.
REQ-020 DWELL end with sampled blank==0: the FSM SHALL go directly to DWELL at the next position, and E SHALL remain continuously high.
REQ-021 Advance: the next position is the next set mask bit above In, searched upward modulo 8, using mask sampled at the advance edge.
REQ-022 Advance with a single set bit equal to In: In SHALL be unchanged, and wrap SHALL pulse.
REQ-023 wrap SHALL pulse for one cycle, coincident with the first cycle of the new DWELL, when new In <= old In; it SHALL be 0 otherwise.
REQ-024 Advance with mask==0: the FSM SHALL go to IDLE, E=0, In held, and no wrap pulse.
REQ-025 stop=1 in DWELL or BLANK: the FSM SHALL go to IDLE on the next edge, E=0 and In held.
REQ-026 stop has priority over start in the same cycle.
REQ-027 start while busy SHALL be ignored.
REQ-028 blank SHALL be sampled on BLANK entry; mask, dwell and blank changes mid-state SHALL not affect the current state's timing.
REQ-029 Dwell and blank counters SHALL not overflow; only sampled-value compares are used.

Reset
REQ-030 Reset SHALL force state=IDLE, E=0, In=3'b000, busy=0, wrap=0 and all counters=0 on the next edge, including mid-DWELL or mid-BLANK.
REQ-031 Reset SHALL have priority over start and stop.
REQ-032 After reset deasserts, the FSM SHALL wait in IDLE for start.

Verification
REQ-033 mask=8'hFF, dwell=0, blank=0, start pulse -> In=0,1,...,7,0 one per cycle; E constantly 1; wrap high the cycle In returns to 0.
REQ-034 mask=8'b1010_0100, dwell=2, blank=1, start -> In=2 with E=1 for 3 cycles, E=0 for 1 cycle; then In=5 and In=7 with the same timing; then In=2 with wrap pulse.
REQ-035 mask=8'h10, dwell=1, blank=0 -> In stays 4, E stays 1, wrap pulses every 2 cycles.
REQ-036 start with mask=0 -> busy stays 0 and E stays 0; start and stop in the same cycle from IDLE -> no change.
REQ-037 stop during BLANK at In=3 -> next cycle busy=0, E=0, In=3; rst asserted mid-DWELL at In=6 -> next cycle In=0, E=0, busy=0.
REQ-038 Mask cleared to 0 during DWELL at In=1 (blank=0) -> at DWELL end the FSM goes to IDLE, E=0, In=1, no wrap.
